// File: rtl/ldst_burst_ctrl_pkg.sv
// Shared widths, FSM encoding and read-tag types for the ldst RAM sequencer.
package ldst_burst_ctrl_pkg;

    localparam int DAT_W  = 32;
    localparam int ADDR_W = 7;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_BRST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/ldst_burst_ctrl_if.sv
// Core, burst-client and RAM signals of the ldst sequencer; slave = controller side.
interface ldst_burst_ctrl_if;
    import ldst_burst_ctrl_pkg::*;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DAT_W-1:0]  core_wdat;
    logic [DAT_W-1:0]  core_rdat;
    logic              core_rvld;

    logic              brst_start;
    logic              brst_we;
    logic [ADDR_W-1:0] brst_base;
    logic [LEN_W-1:0]  brst_len;
    logic [DAT_W-1:0]  brst_wdat;
    logic              brst_wrdy;
    logic [DAT_W-1:0]  brst_rdat;
    logic              brst_rvld;
    logic              brst_busy;
    logic              brst_done;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DAT_W-1:0]  ram_wdat;
    logic [DAT_W-1:0]  ram_rdat;

    modport slave (
        input  core_req, core_we, core_addr, core_wdat,
        output core_rdat, core_rvld,
        input  brst_start, brst_we, brst_base, brst_len, brst_wdat,
        output brst_wrdy, brst_rdat, brst_rvld, brst_busy, brst_done,
        output ram_en, ram_we, ram_addr, ram_wdat,
        input  ram_rdat
    );

    modport master (
        output core_req, core_we, core_addr, core_wdat,
        input  core_rdat, core_rvld,
        output brst_start, brst_we, brst_base, brst_len, brst_wdat,
        input  brst_wrdy, brst_rdat, brst_rvld, brst_busy, brst_done,
        input  ram_en, ram_we, ram_addr, ram_wdat,
        output ram_rdat
    );

endinterface

// File: rtl/ldst_burst_ctrl_rd_tag.sv
// One-deep read tag: remembers who issued last cycle's RAM read and steers ram_rdat back.
module ldst_rd_tag
    import ldst_burst_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             rd_issue,
    input  owner_e           rd_owner,
    input  logic [DAT_W-1:0] ram_rdat,
    output logic [DAT_W-1:0] core_rdat,
    output logic             core_rvld,
    output logic [DAT_W-1:0] brst_rdat,
    output logic             brst_rvld
);

    rd_tag_t tag;

    always_ff @(posedge clk) begin
        if (rst_b) tag <= '0;
        else       tag <= '{vld: rd_issue, owner: rd_owner};
    end

    // RAM data is already one cycle late, so only the tag is registered;
    // data is zeroed when not valid so idle ports stay quiet.
    always_comb begin
        core_rvld = tag.vld && (tag.owner == OWN_CORE) && !rst_b;
        brst_rvld = tag.vld && (tag.owner == OWN_BRST) && !rst_b;
        core_rdat = core_rvld ? ram_rdat : '0;
        brst_rdat = brst_rvld ? ram_rdat : '0;
    end

endmodule

// File: rtl/ldst_burst_ctrl.sv
// Arbitrates the single-port data RAM between core single accesses (priority) and a burst engine.
module ldst_burst_ctrl
    import ldst_burst_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_b,
    ldst_burst_ctrl_if.slave   bus
);

    state_e            state;
    logic [ADDR_W-1:0] addr_ctr;
    logic [LEN_W-1:0]  rem;
    logic              we_q;
    logic              core_gnt;
    logic              brst_gnt;

    assign core_gnt = bus.core_req && !rst_b;
    assign brst_gnt = (state == ST_RUN) && !bus.core_req && !rst_b;

    always_comb begin
        bus.ram_en    = core_gnt || brst_gnt;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdat  = '0;
        bus.brst_wrdy = brst_gnt && we_q;
        if (core_gnt) begin
            bus.ram_we   = bus.core_we;
            bus.ram_addr = bus.core_addr;
            bus.ram_wdat = bus.core_we ? bus.core_wdat : '0;
        end else if (brst_gnt) begin
            bus.ram_we   = we_q;
            bus.ram_addr = addr_ctr;
            bus.ram_wdat = we_q ? bus.brst_wdat : '0;
        end
        bus.brst_busy = (state != ST_IDLE) && !rst_b;
        bus.brst_done = (state == ST_FIN) && !rst_b;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state    <= ST_IDLE;
            addr_ctr <= '0;
            rem      <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.brst_start) begin
                    if (bus.brst_len != '0) begin
                        addr_ctr <= bus.brst_base;
                        rem      <= bus.brst_len;
                        we_q     <= bus.brst_we;
                        state    <= ST_RUN;
                    end else begin
                        state    <= ST_FIN;
                    end
                end
                // Counters only move on a granted cycle; a core access stalls the burst.
                ST_RUN: if (brst_gnt) begin
                    addr_ctr <= addr_ctr + 1'b1;
                    rem      <= rem - 1'b1;
                    if (rem == LEN_W'(1)) state <= ST_FIN;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ldst_rd_tag u_rd_tag (
        .clk       (clk),
        .rst_b     (rst_b),
        .rd_issue  (bus.ram_en && !bus.ram_we),
        .rd_owner  (core_gnt ? OWN_CORE : OWN_BRST),
        .ram_rdat  (bus.ram_rdat),
        .core_rdat (bus.core_rdat),
        .core_rvld (bus.core_rvld),
        .brst_rdat (bus.brst_rdat),
        .brst_rvld (bus.brst_rvld)
    );

endmodule
